// File: rtl/load_cell_controller_if.sv
// Signal bundle between the HX711 reader/application side and load_cell_controller.
// The master side drives the reader status and the application requests; the slave side is the controller.
interface load_cell_controller_if;
    logic               hx_dout_raw;
    logic               rd_data_in;
    logic               rd_delay_call;
    logic               rd_delay_continue;
    logic               rd_shift_out;
    logic        [23:0] rd_data_out;
    logic               enable;
    logic               tare_req;
    logic signed [31:0] weight;
    logic               weight_valid;
    logic               tare_busy;
    logic               tare_done;
    logic               timeout;

    modport master (
        output hx_dout_raw, rd_delay_call, rd_shift_out, rd_data_out, enable, tare_req,
        input  rd_data_in, rd_delay_continue, weight, weight_valid, tare_busy, tare_done, timeout
    );

    modport slave (
        input  hx_dout_raw, rd_delay_call, rd_shift_out, rd_data_out, enable, tare_req,
        output rd_data_in, rd_delay_continue, weight, weight_valid, tare_busy, tare_done, timeout
    );
endinterface

// File: rtl/load_cell_controller.sv
// HX711 sequencing controller: DOUT sync/gating, reader delay server, sample averaging,
// tare capture and no-data watchdog, all in the CLK_50 domain.
module load_cell_controller #(
    parameter int DELAY_CYCLES   = 50,
    parameter int AVG_LOG2       = 2,
    parameter int TARE_LOG2      = 3,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic                  CLK_50,
    input  logic                  RESET_N,
    load_cell_controller_if.slave bus
);
    localparam int MAX_LOG2 = (AVG_LOG2 > TARE_LOG2) ? AVG_LOG2 : TARE_LOG2;
    localparam int ACC_W    = 24 + MAX_LOG2;
    localparam int CNT_W    = MAX_LOG2 + 1;
    localparam int DLY_W    = $clog2(DELAY_CYCLES + 1);
    localparam int TMR_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] AVG_N  = CNT_W'(2 ** AVG_LOG2);
    localparam logic [CNT_W-1:0] TARE_N = CNT_W'(2 ** TARE_LOG2);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_RESULT = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    function automatic logic signed [ACC_W-1:0] sext_sample(input logic [23:0] d);
        return {{(ACC_W-24){d[23]}}, d};
    endfunction

    // Arithmetic shift floors toward -inf; the mean of 24-bit samples always fits in 32 bits.
    function automatic logic signed [31:0] mean32(input logic signed [ACC_W-1:0] a, input int sh);
        logic signed [ACC_W-1:0] s;
        s = a >>> sh;
        return 32'(s);
    endfunction

    logic                    sync1_q, sync2_q;
    logic [DLY_W-1:0]        dly_q, dly_d;
    logic                    cont_q, cont_d;
    logic                    shift_q, cap_q;
    logic                    busy_q, busy_d;
    logic [1:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic                    timeout_q, timeout_d;
    logic signed [31:0]      weight_q, weight_d;
    logic                    valid_q, valid_d;
    logic signed [31:0]      tare_off_q, tare_off_d;
    logic                    tare_busy_q, tare_busy_d;
    logic                    done_q, done_d;
    logic                    pend_q, pend_d;

    logic signed [ACC_W-1:0] sample;
    logic [CNT_W-1:0]        cnt_inc;
    logic [CNT_W-1:0]        win_n;
    logic                    tare_go;

    assign sample  = sext_sample(bus.rd_data_out);
    assign cnt_inc = cnt_q + 1'b1;
    assign win_n   = tare_busy_q ? TARE_N : AVG_N;
    assign tare_go = bus.tare_req & ~tare_busy_q;

    // A call mid-count reloads the counter, so only the latest call produces a continue.
    always_comb begin
        dly_d  = dly_q;
        cont_d = 1'b0;
        if (bus.rd_delay_call) begin
            dly_d = DLY_W'(DELAY_CYCLES - 1);
        end else if (dly_q != '0) begin
            dly_d  = dly_q - 1'b1;
            cont_d = (dly_q == DLY_W'(1));
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (cap_q)             busy_d = 1'b0;
        if (bus.rd_delay_call) busy_d = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        tmr_d       = tmr_q;
        timeout_d   = timeout_q;
        weight_d    = weight_q;
        valid_d     = 1'b0;
        tare_off_d  = tare_off_q;
        tare_busy_d = tare_busy_q;
        done_d      = 1'b0;
        pend_d      = pend_q;
        case (state_q)
            S_IDLE: begin
                if (tare_go) pend_d = 1'b1;
                if (bus.enable) begin
                    state_d = S_WAIT;
                    acc_d   = '0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    if (tare_go || pend_q) begin
                        tare_busy_d = 1'b1;
                        pend_d      = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    tmr_d     = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
                if (cap_q) begin
                    tmr_d     = '0;
                    timeout_d = 1'b0;
                end
                // Starting a tare throws away the partial window, including a same-cycle capture.
                if (tare_go) begin
                    tare_busy_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    if (!bus.enable) state_d = S_DRAIN;
                end else if (cap_q) begin
                    acc_d = acc_q + sample;
                    cnt_d = cnt_inc;
                    if (cnt_inc == win_n)  state_d = S_RESULT;
                    else if (!bus.enable)  state_d = S_DRAIN;
                end else if (!bus.enable) begin
                    state_d = S_DRAIN;
                end
            end
            S_RESULT: begin
                acc_d = '0;
                cnt_d = '0;
                if (tare_busy_q) begin
                    tare_off_d  = mean32(acc_q, TARE_LOG2);
                    done_d      = 1'b1;
                    tare_busy_d = 1'b0;
                end else begin
                    weight_d = mean32(acc_q, AVG_LOG2) - tare_off_q;
                    valid_d  = 1'b1;
                end
                if (bus.enable) begin
                    state_d = S_WAIT;
                    if (tare_go) tare_busy_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    if (tare_go) pend_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (tare_go) pend_d = 1'b1;
                if (!busy_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            dly_q       <= '0;
            cont_q      <= 1'b0;
            shift_q     <= 1'b0;
            cap_q       <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            timeout_q   <= 1'b0;
            weight_q    <= '0;
            valid_q     <= 1'b0;
            tare_off_q  <= '0;
            tare_busy_q <= 1'b0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            sync1_q     <= bus.hx_dout_raw;
            sync2_q     <= sync1_q;
            dly_q       <= dly_d;
            cont_q      <= cont_d;
            shift_q     <= bus.rd_shift_out;
            cap_q       <= bus.rd_shift_out & ~shift_q;
            busy_q      <= busy_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            timeout_q   <= timeout_d;
            weight_q    <= weight_d;
            valid_q     <= valid_d;
            tare_off_q  <= tare_off_d;
            tare_busy_q <= tare_busy_d;
            done_q      <= done_d;
            pend_q      <= pend_d;
        end
    end

    // DOUT reaches the reader only while a conversion may start or one is already in flight.
    assign bus.rd_data_in        = (state_q == S_WAIT || busy_q) ? sync2_q : 1'b1;
    assign bus.rd_delay_continue = cont_q;
    assign bus.weight            = weight_q;
    assign bus.weight_valid      = valid_q;
    assign bus.tare_busy         = tare_busy_q;
    assign bus.tare_done         = done_q;
    assign bus.timeout           = timeout_q;
endmodule

// File: tb/tb_load_cell_controller.sv
// Bench for load_cell_controller: an HX711 + reader model shifts random conversions through the
// controller, and expected weights come from floor-averaging the sent values in plain arithmetic.
module tb_load_cell_controller;
    localparam int DLY  = 4;
    localparam int AVG  = 2;
    localparam int TARE = 3;
    localparam int TMO  = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_cell_controller_if bus();

    load_cell_controller #(
        .DELAY_CYCLES(DLY), .AVG_LOG2(AVG), .TARE_LOG2(TARE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK_50 (clk),
        .RESET_N(rst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_done  = 0;

    always @(posedge clk) begin
        if (bus.weight_valid === 1'b1) n_valid++;
        if (bus.tare_done === 1'b1)    n_done++;
    end

    function automatic longint floor_div(input longint s, input longint n);
        longint r;
        r = s % n;
        if (r < 0) r += n;
        return (s - r) / n;
    endfunction

    function automatic longint sval(input logic [23:0] v);
        longint x;
        x = $signed(v);
        return x;
    endfunction

    task automatic apply_reset();
        bus.hx_dout_raw   = 1'b1;
        bus.rd_delay_call = 1'b0;
        bus.rd_shift_out  = 1'b0;
        bus.rd_data_out   = 24'h0;
        bus.enable        = 1'b0;
        bus.tare_req      = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Starts at a negedge: raises delay_call for one cycle, returns cycles until continue.
    task automatic pulse_delay(output int lat);
        bus.rd_delay_call = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            bus.rd_delay_call = 1'b0;
            lat++;
        end while (bus.rd_delay_continue !== 1'b1 && lat < 100);
    endtask

    // HX711 + reader: 24 data pulses plus one gain pulse, then shift_out and data_out update.
    task automatic xfer(input logic [23:0] val, input int drop_at,
                        output logic [23:0] got, output bit ok);
        int lat;
        int w;
        ok  = 1'b1;
        got = 24'h0;
        @(negedge clk);
        bus.hx_dout_raw = 1'b0;
        w = 0;
        while (bus.rd_data_in !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            ok = 1'b0;
            bus.hx_dout_raw = 1'b1;
            return;
        end
        for (int b = 0; b < 25; b++) begin
            if (b == drop_at) bus.enable = 1'b0;
            pulse_delay(lat);
            if (lat != DLY) ok = 1'b0;
            bus.hx_dout_raw = (b < 24) ? val[23-b] : 1'b1;
            pulse_delay(lat);
            if (lat != DLY) ok = 1'b0;
            if (b < 24) got[23-b] = bus.rd_data_in;
        end
        bus.rd_shift_out = 1'b1;
        @(negedge clk);
        bus.rd_shift_out = 1'b0;
        bus.rd_data_out  = got;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        total += 7;
        if (bus.rd_data_in !== 1'b1)        begin bad++; $display("FAIL reset_rd_data_in got=%b want=1", bus.rd_data_in); end
        if (bus.rd_delay_continue !== 1'b0) begin bad++; $display("FAIL reset_continue got=%b want=0", bus.rd_delay_continue); end
        if (bus.weight !== 32'sd0)          begin bad++; $display("FAIL reset_weight got=%0d want=0", bus.weight); end
        if (bus.weight_valid !== 1'b0)      begin bad++; $display("FAIL reset_weight_valid got=%b want=0", bus.weight_valid); end
        if (bus.tare_busy !== 1'b0)         begin bad++; $display("FAIL reset_tare_busy got=%b want=0", bus.tare_busy); end
        if (bus.tare_done !== 1'b0)         begin bad++; $display("FAIL reset_tare_done got=%b want=0", bus.tare_done); end
        if (bus.timeout !== 1'b0)           begin bad++; $display("FAIL reset_timeout got=%b want=0", bus.timeout); end
    endtask

    task automatic test_delay();
        int seen;
        apply_reset();
        repeat (5) @(negedge clk);
        bus.rd_delay_call = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus.rd_delay_call = 1'b0;
            total++;
            if (bus.rd_delay_continue !== (k == DLY)) begin
                bad++; $display("FAIL delay_single k=%0d got=%b want=%b", k, bus.rd_delay_continue, (k == DLY));
            end
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rd_delay_continue === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL delay_no_call got=%0d pulses want=0", seen); end
        bus.rd_delay_call = 1'b1;
        @(negedge clk);
        bus.rd_delay_call = 1'b0;
        @(negedge clk);
        bus.rd_delay_call = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus.rd_delay_call = 1'b0;
            total++;
            if (bus.rd_delay_continue !== (k == DLY)) begin
                bad++; $display("FAIL delay_restart k=%0d got=%b want=%b", k, bus.rd_delay_continue, (k == DLY));
            end
        end
    endtask

    // Sends one averaging window and checks the published weight against floor(mean) - offset.
    task automatic send_window(input logic [23:0] vals[4], input longint offset, input string tag);
        logic [23:0] got;
        bit ok;
        longint sum;
        int v0;
        logic signed [31:0] exp_w;
        v0  = n_valid;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            xfer(vals[i], -1, got, ok);
            sum += sval(vals[i]);
            total += 2;
            if (!ok)          begin bad++; $display("FAIL %s_xfer_timing i=%0d got=0 want=1", tag, i); end
            if (got !== vals[i]) begin bad++; $display("FAIL %s_data_in i=%0d got=%h want=%h", tag, i, got, vals[i]); end
        end
        repeat (4) @(negedge clk);
        exp_w = 32'(floor_div(sum, 4) - offset);
        total += 2;
        if (n_valid - v0 != 1) begin bad++; $display("FAIL %s_valid_count got=%0d want=1", tag, n_valid - v0); end
        if (bus.weight !== exp_w) begin bad++; $display("FAIL %s_weight got=%0d want=%0d", tag, bus.weight, exp_w); end
    endtask

    task automatic test_average();
        logic [23:0] w[4];
        apply_reset();
        bus.enable = 1'b1;
        w = '{24'd100, 24'd104, 24'd96, 24'd100};
        send_window(w, 0, "avg_fixed");
        w = '{24'hFFFFF6, 24'hFFFFF6, 24'hFFFFF6, 24'hFFFFF6};
        send_window(w, 0, "avg_neg");
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) w[i] = 24'($urandom);
            send_window(w, 0, "avg_rand");
        end
    endtask

    // Sends a full tare window; returns the offset the specification's rule predicts.
    task automatic send_tare(input logic [23:0] vals[8], input bit second_req, output longint offset);
        logic [23:0] got;
        bit ok;
        longint sum;
        int d0, v0;
        d0  = n_done;
        v0  = n_valid;
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            xfer(vals[i], -1, got, ok);
            sum += sval(vals[i]);
            total++;
            if (!ok || got !== vals[i]) begin bad++; $display("FAIL tare_xfer i=%0d got=%h want=%h", i, got, vals[i]); end
            if (second_req && i == 2) begin
                @(negedge clk); bus.tare_req = 1'b1;
                @(negedge clk); bus.tare_req = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
        offset = floor_div(sum, 8);
        total += 3;
        if (n_done - d0 != 1)  begin bad++; $display("FAIL tare_done_count got=%0d want=1", n_done - d0); end
        if (bus.tare_busy !== 1'b0) begin bad++; $display("FAIL tare_busy_after got=%b want=0", bus.tare_busy); end
        if (n_valid - v0 != 0) begin bad++; $display("FAIL tare_no_valid got=%0d want=0", n_valid - v0); end
    endtask

    task automatic test_tare();
        logic [23:0] t[8];
        logic [23:0] w[4];
        longint off;
        int base;
        apply_reset();
        @(negedge clk); bus.tare_req = 1'b1;
        @(negedge clk); bus.tare_req = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.tare_busy !== 1'b0) begin bad++; $display("FAIL tare_idle_busy got=%b want=0", bus.tare_busy); end
        bus.enable = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.tare_busy !== 1'b1) begin bad++; $display("FAIL tare_latched_busy got=%b want=1", bus.tare_busy); end
        for (int i = 0; i < 8; i++) t[i] = 24'd5000;
        send_tare(t, 1'b1, off);
        w = '{24'd5250, 24'd5250, 24'd5250, 24'd5250};
        send_window(w, off, "tare_fixed");

        @(negedge clk); bus.tare_req = 1'b1;
        @(negedge clk); bus.tare_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus.tare_busy !== 1'b1) begin bad++; $display("FAIL tare_wait_busy got=%b want=1", bus.tare_busy); end
        base = int'($urandom_range(0, 2000000)) - 1000000;
        for (int i = 0; i < 8; i++) t[i] = 24'(base + int'($urandom_range(0, 50)));
        send_tare(t, 1'b0, off);
        for (int i = 0; i < 4; i++) w[i] = 24'(base + int'($urandom_range(0, 400000)) - 200000);
        send_window(w, off, "tare_rand");
    endtask

    task automatic test_timeout();
        logic [23:0] got;
        bit ok;
        apply_reset();
        @(negedge clk);
        bus.enable = 1'b1;
        repeat (TMO) @(negedge clk);
        total++;
        if (bus.timeout !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b want=0", bus.timeout); end
        @(negedge clk);
        total++;
        if (bus.timeout !== 1'b1) begin bad++; $display("FAIL timeout_set got=%b want=1", bus.timeout); end
        xfer(24'($urandom), -1, got, ok);
        total++;
        if (bus.timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b want=0", bus.timeout); end
    endtask

    task automatic test_enable_drop();
        logic [23:0] got;
        logic [23:0] v;
        logic [23:0] w[4];
        bit ok;
        int v0;
        apply_reset();
        bus.enable = 1'b1;
        v0 = n_valid;
        v  = 24'($urandom);
        xfer(v, 12, got, ok);
        total += 2;
        if (!ok)      begin bad++; $display("FAIL drop_pulses got=0 want=1"); end
        if (got !== v) begin bad++; $display("FAIL drop_data got=%h want=%h", got, v); end
        repeat (4) @(negedge clk);
        bus.hx_dout_raw = 1'b0;
        repeat (6) @(negedge clk);
        total += 2;
        if (bus.rd_data_in !== 1'b1) begin bad++; $display("FAIL drop_gated got=%b want=1", bus.rd_data_in); end
        if (n_valid != v0)           begin bad++; $display("FAIL drop_no_valid got=%0d want=0", n_valid - v0); end
        bus.enable = 1'b1;
        for (int i = 0; i < 4; i++) w[i] = 24'($urandom);
        send_window(w, 0, "drop_resume");
    endtask

    task automatic test_reset_mid();
        int w;
        int lat;
        @(negedge clk); bus.tare_req = 1'b1;
        @(negedge clk); bus.tare_req = 1'b0;
        bus.hx_dout_raw = 1'b0;
        w = 0;
        while (bus.rd_data_in !== 1'b0 && w < 100) begin @(negedge clk); w++; end
        total += 2;
        if (bus.rd_data_in !== 1'b0) begin bad++; $display("FAIL rmid_pre_data got=%b want=0", bus.rd_data_in); end
        if (bus.tare_busy !== 1'b1)  begin bad++; $display("FAIL rmid_pre_busy got=%b want=1", bus.tare_busy); end
        bus.rd_delay_call = 1'b1;
        @(negedge clk);
        bus.rd_delay_call = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total += 7;
        if (bus.rd_data_in !== 1'b1)        begin bad++; $display("FAIL rmid_rd_data_in got=%b want=1", bus.rd_data_in); end
        if (bus.rd_delay_continue !== 1'b0) begin bad++; $display("FAIL rmid_continue got=%b want=0", bus.rd_delay_continue); end
        if (bus.weight !== 32'sd0)          begin bad++; $display("FAIL rmid_weight got=%0d want=0", bus.weight); end
        if (bus.weight_valid !== 1'b0)      begin bad++; $display("FAIL rmid_valid got=%b want=0", bus.weight_valid); end
        if (bus.tare_busy !== 1'b0)         begin bad++; $display("FAIL rmid_tare_busy got=%b want=0", bus.tare_busy); end
        if (bus.tare_done !== 1'b0)         begin bad++; $display("FAIL rmid_tare_done got=%b want=0", bus.tare_done); end
        if (bus.timeout !== 1'b0)           begin bad++; $display("FAIL rmid_timeout got=%b want=0", bus.timeout); end
        repeat (DLY + 2) @(negedge clk);
        total++;
        if (bus.rd_delay_continue !== 1'b0) begin bad++; $display("FAIL rmid_no_continue got=%b want=0", bus.rd_delay_continue); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #900_000;
        bad++;
        $display("FAIL watchdog got=running want=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_delay();
        test_average();
        test_tare();
        test_timeout();
        test_enable_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_cell_controller.md
Name: load_cell_controller

Overview:
- Sequences and services the HX711 bit-bang reader (read_load_cell) from a single CLK_50 domain.
- Synchronizes the raw DOUT pin and gates it to the reader.
- Serves the reader's delay_call/delay_continue timing handshake.
- Collects 24-bit conversions, averages them, applies a tare offset, and publishes a signed weight with a one-cycle valid strobe; also provides tare capture and a no-data watchdog.

Parameters:
- DELAY_CYCLES, 50, CLK_50 cycles from delay call to continue pulse (1 us); legal range 2..2500.
- AVG_LOG2, 2, log2 of samples averaged per published weight (4).
- TARE_LOG2, 3, log2 of samples averaged for tare capture (8).
- TIMEOUT_CYCLES, 10_000_000, cycles in WAIT without a sample before timeout is flagged (200 ms).

Ports:
- CLK_50  in  1  system clock, 50 MHz.
- RESET_N  in  1  reset; one clock; reset is asynchronous and active-low.
- hx_dout_raw  in  1  raw HX711 DOUT pin, asynchronous.
- rd_data_in  out  1  synchronized, gated DOUT to the reader's data_in.
- rd_delay_call  in  1  reader's delay_call, one-cycle pulse.
- rd_delay_continue  out  1  one-cycle pulse to the reader's delay_continue.
- rd_shift_out  in  1  reader's shift_out (high only in REGISTER_RESULT).
- rd_data_out  in  24  reader's data_out, two's complement.
- enable  in  1  level; run conversions while high.
- tare_req  in  1  one-cycle request to re-tare.
- weight  out  32  signed averaged weight minus tare offset.
- weight_valid  out  1  one-cycle strobe when weight updates.
- tare_busy  out  1  high while a tare window is accumulating.
- tare_done  out  1  one-cycle strobe when tare_offset updates.
- timeout  out  1  sticky no-data flag.

Behaviour:
- Reset values: rd_data_in=1, rd_delay_continue=0, weight=0, weight_valid=0, tare_busy=0, tare_done=0, timeout=0. Internal: tare_offset=0, acc=0, cnt=0, busy=0, state=IDLE.
- Synchronizer: two flops on hx_dout_raw, both reset to 1 (DOUT high means not ready).
- Gating: rd_data_in = dout_sync when state==WAIT or busy, else 1. The reader therefore never starts in IDLE or DRAIN, and is never starved mid-transfer.
- busy flag: set on any cycle with rd_delay_call=1; cleared on the sample-capture cycle.
- Delay server:
  - rd_delay_call=1 at cycle t loads a down-counter; rd_delay_continue=1 for exactly one cycle at t+DELAY_CYCLES.
  - A call during an active count restarts the count.
  - No call means no continue pulse.
- Sample capture:
  - Rising edge of rd_shift_out is detected with one registration flop.
  - On the cycle after the edge, rd_data_out (now updated by the reader) is sign-extended to 32 bits and captured.
- FSM states: IDLE, WAIT, RESULT, DRAIN.
  - IDLE: enable=1 -> WAIT; acc, cnt and the timeout timer are cleared.
  - WAIT, on capture: acc+=sample, cnt+=1, timeout cleared, timer reloaded.
    - Normal mode: cnt reaching 2^AVG_LOG2 -> RESULT.
    - Tare mode: cnt reaching 2^TARE_LOG2 -> RESULT.
  - WAIT, timer reaches TIMEOUT_CYCLES: timeout=1, timer reloads, state stays WAIT.
  - WAIT, enable=0: -> DRAIN.
  - RESULT, one cycle, then acc and cnt cleared:
    - Normal mode: weight=(acc>>>AVG_LOG2)-tare_offset, weight_valid=1.
    - Tare mode: tare_offset=acc>>>TARE_LOG2, tare_done=1, tare_busy=0.
    - Next state is WAIT if enable, else IDLE.
  - DRAIN: waits for busy=0 (a capture is discarded, not accumulated), then -> IDLE. Partial acc is discarded.
- Arithmetic:
  - acc is signed, 24+max(AVG_LOG2,TARE_LOG2) bits.
  - Shifts are arithmetic (round toward negative infinity).
  - The subtraction cannot overflow 32 bits.
- Tare:
  - tare_req with tare_busy=0 sets tare mode and tare_busy=1 the next cycle, and clears acc and cnt. The partial normal window is discarded; a capture in that same cycle is discarded.
  - tare_req while tare_busy=1 is ignored.
  - tare_req in IDLE or DRAIN is latched and takes effect on entry to WAIT.
- Simultaneous events:
  - Capture and enable fall in the same cycle: the sample counts; the state then follows the rules above.
  - RESULT and tare_req in the same cycle: RESULT completes first, then tare starts.
- Weight persists until the next RESULT; enable=0 does not clear it.

Test Plan:
- Delay timing: DELAY_CYCLES=4; pulse rd_delay_call at cycle 10 -> rd_delay_continue high only at cycle 14; no call -> continue never asserts.
- Averaging: reader + HX711 model with AVG_LOG2=2, samples 100,104,96,100 -> one weight_valid, weight=100; samples 0xFFFFF6 ×4 (-10) -> weight=-10 (0xFFFFFFF6).
- Tare: TARE_LOG2=3, eight samples of 5000, then four of 5250 -> tare_done once, tare_busy low after; weight=250. A second tare_req mid-tare is ignored (still 8 samples).
- Timeout: TIMEOUT_CYCLES=1000, DOUT held high -> timeout=1 at cycle 1000 after entering WAIT; the next sample clears it.
- Enable drop mid-transfer: deassert enable during bit 12 -> reader still receives 25 clean pulses with valid data_in; no weight_valid; FSM reaches IDLE; rd_data_in=1 afterward.
- Reset mid-operation: assert RESET_N low during DELAY_WAIT -> all outputs return to reset values immediately; rd_delay_continue=0 and rd_data_in=1.
